// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory's single combinational read
// port between the fetch stage and the debug/loader port. Each port gets a
// valid/ready request channel and a registered, back-pressurable response.
module imem_arbiter #(
  parameter int unsigned IMEM_W     = 14,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch port
  input  logic              f_req_valid_i,
  input  logic [IMEM_W-1:0] f_req_addr_i,
  output logic              f_req_ready_o,
  output logic              f_rsp_valid_o,
  output logic [31:0]       f_rsp_data_o,
  output logic              f_rsp_err_o,
  input  logic              f_rsp_ready_i,
  // debug/loader port
  input  logic              d_req_valid_i,
  input  logic [IMEM_W-1:0] d_req_addr_i,
  output logic              d_req_ready_o,
  output logic              d_rsp_valid_o,
  output logic [31:0]       d_rsp_data_o,
  output logic              d_rsp_err_o,
  input  logic              d_rsp_ready_i,
  // memory read port
  output logic [IMEM_W-1:0] paddr_o,
  input  logic [31:0]       prdata_i
);

  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(15);
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_MAX);

  logic              f_free;
  logic              d_free;
  logic              f_elig;
  logic              d_elig;
  logic              d_prio;
  logic              grant_f;
  logic              grant_d;

  logic              f_valid_q, f_valid_d;
  logic [31:0]       f_data_q,  f_data_d;
  logic              f_err_q,   f_err_d;
  logic              d_valid_q, d_valid_d;
  logic [31:0]       d_data_q,  d_data_d;
  logic              d_err_q,   d_err_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  // Arbitration: fetch wins unless debug has been starved long enough.
  // Grants are suppressed while reset is asserted so nothing is accepted then.
  always_comb begin
    f_free  = !f_valid_q || f_rsp_ready_i;
    d_free  = !d_valid_q || d_rsp_ready_i;
    f_elig  = f_req_valid_i && f_free;
    d_elig  = d_req_valid_i && d_free;
    d_prio  = (starve_cnt_q >= STARVE_TH);
    grant_f = !rst_i && f_elig && !(d_elig && d_prio);
    grant_d = !rst_i && d_elig && !grant_f;
  end

  // Memory address mux; defaults to the fetch address when idle.
  always_comb begin
    paddr_o = f_req_addr_i;
    if (grant_d) begin
      paddr_o = d_req_addr_i;
    end
  end

  assign f_req_ready_o = grant_f;
  assign d_req_ready_o = grant_d;

  // Fetch response slot: capture on grant, otherwise drain when consumed.
  always_comb begin
    f_valid_d = f_valid_q;
    f_data_d  = f_data_q;
    f_err_d   = f_err_q;
    if (grant_f) begin
      f_valid_d = 1'b1;
      f_data_d  = prdata_i;
      f_err_d   = |f_req_addr_i[1:0];
    end else if (f_rsp_ready_i) begin
      f_valid_d = 1'b0;
    end
  end

  // Debug response slot: same behaviour, independent of fetch traffic.
  always_comb begin
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;
    d_err_d   = d_err_q;
    if (grant_d) begin
      d_valid_d = 1'b1;
      d_data_d  = prdata_i;
      d_err_d   = |d_req_addr_i[1:0];
    end else if (d_rsp_ready_i) begin
      d_valid_d = 1'b0;
    end
  end

  // Starvation counter: counts denied debug cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_d || !d_req_valid_i) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_SAT) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Response and counter registers; reset discards pending responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_valid_q    <= 1'b0;
      f_data_q     <= '0;
      f_err_q      <= 1'b0;
      d_valid_q    <= 1'b0;
      d_data_q     <= '0;
      d_err_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      f_valid_q    <= f_valid_d;
      f_data_q     <= f_data_d;
      f_err_q      <= f_err_d;
      d_valid_q    <= d_valid_d;
      d_data_q     <= d_data_d;
      d_err_q      <= d_err_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign f_rsp_valid_o = f_valid_q;
  assign f_rsp_data_o  = f_data_q;
  assign f_rsp_err_o   = f_err_q;
  assign d_rsp_valid_o = d_valid_q;
  assign d_rsp_data_o  = d_data_q;
  assign d_rsp_err_o   = d_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: two instances (STARVE_MAX 4 and 15), each
// in front of a behavioural memory holding word[k] = 0xA000_0000 + k.
module tb_imem_arbiter;

  localparam int unsigned AW = 14;

  logic clk;
  logic rst;

  // instance A signals (STARVE_MAX = 4)
  logic          a_f_vld, a_f_rdy, a_f_rv, a_f_err, a_f_rr;
  logic [AW-1:0] a_f_addr;
  logic [31:0]   a_f_data;
  logic          a_d_vld, a_d_rdy, a_d_rv, a_d_err, a_d_rr;
  logic [AW-1:0] a_d_addr;
  logic [31:0]   a_d_data;
  logic [AW-1:0] a_paddr;
  logic [31:0]   a_prdata;

  // instance B signals (STARVE_MAX = 15)
  logic          b_f_vld, b_f_rdy, b_f_rv, b_f_err, b_f_rr;
  logic [AW-1:0] b_f_addr;
  logic [31:0]   b_f_data;
  logic          b_d_vld, b_d_rdy, b_d_rv, b_d_err, b_d_rr;
  logic [AW-1:0] b_d_addr;
  logic [31:0]   b_d_data;
  logic [AW-1:0] b_paddr;
  logic [31:0]   b_prdata;

  int checks = 0;
  int errors = 0;

  assign a_prdata = 32'hA000_0000 + 32'(a_paddr[AW-1:2]);
  assign b_prdata = 32'hA000_0000 + 32'(b_paddr[AW-1:2]);

  imem_arbiter #(.IMEM_W(AW), .STARVE_MAX(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .f_req_valid_i(a_f_vld), .f_req_addr_i(a_f_addr), .f_req_ready_o(a_f_rdy),
    .f_rsp_valid_o(a_f_rv), .f_rsp_data_o(a_f_data), .f_rsp_err_o(a_f_err),
    .f_rsp_ready_i(a_f_rr),
    .d_req_valid_i(a_d_vld), .d_req_addr_i(a_d_addr), .d_req_ready_o(a_d_rdy),
    .d_rsp_valid_o(a_d_rv), .d_rsp_data_o(a_d_data), .d_rsp_err_o(a_d_err),
    .d_rsp_ready_i(a_d_rr),
    .paddr_o(a_paddr), .prdata_i(a_prdata)
  );

  imem_arbiter #(.IMEM_W(AW), .STARVE_MAX(15)) u_b (
    .clk_i(clk), .rst_i(rst),
    .f_req_valid_i(b_f_vld), .f_req_addr_i(b_f_addr), .f_req_ready_o(b_f_rdy),
    .f_rsp_valid_o(b_f_rv), .f_rsp_data_o(b_f_data), .f_rsp_err_o(b_f_err),
    .f_rsp_ready_i(b_f_rr),
    .d_req_valid_i(b_d_vld), .d_req_addr_i(b_d_addr), .d_req_ready_o(b_d_rdy),
    .d_rsp_valid_o(b_d_rv), .d_rsp_data_o(b_d_data), .d_rsp_err_o(b_d_err),
    .d_rsp_ready_i(b_d_rr),
    .paddr_o(b_paddr), .prdata_i(b_prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_f_vld = 0; a_f_addr = '0; a_f_rr = 1;
    a_d_vld = 0; a_d_addr = '0; a_d_rr = 1;
    b_f_vld = 0; b_f_addr = '0; b_f_rr = 1;
    b_d_vld = 0; b_d_addr = '0; b_d_rr = 1;
    tick;

    // reset: requests pending but no ready while rst is high
    a_f_vld = 1; a_d_vld = 1;
    #1;
    chk("rst_f_ready", 32'(a_f_rdy), 0);
    chk("rst_d_ready", 32'(a_d_rdy), 0);
    tick;
    chk("rst_f_valid", 32'(a_f_rv), 0);
    chk("rst_d_valid", 32'(a_d_rv), 0);
    chk("rst_f_data", a_f_data, 0);
    chk("rst_starve", 32'(u_a.starve_cnt_q), 0);
    a_f_vld = 0; a_d_vld = 0;
    rst = 1'b0;
    tick;

    // fetch alone: three back-to-back reads
    for (int k = 0; k < 3; k++) begin
      a_f_vld = 1; a_f_addr = AW'(4 * k);
      #1;
      chk("fa_ready", 32'(a_f_rdy), 1);
      tick;
      chk("fa_valid", 32'(a_f_rv), 1);
      chk("fa_data", a_f_data, 32'hA000_0000 + 32'(k));
      chk("fa_err", 32'(a_f_err), 0);
    end
    a_f_vld = 0;
    #1;
    tick;
    chk("fa_drain", 32'(a_f_rv), 0);

    // contention: fetch four times, then debug, then fetch again
    a_f_vld = 1; a_f_addr = AW'('h10);
    a_d_vld = 1; a_d_addr = AW'('h20);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("ct_f_ready", 32'(a_f_rdy), (c != 4) ? 1 : 0);
      chk("ct_d_ready", 32'(a_d_rdy), (c == 4) ? 1 : 0);
      tick;
      if (c == 3) chk("ct_starve4", 32'(u_a.starve_cnt_q), 4);
      if (c == 4) begin
        chk("ct_starve0", 32'(u_a.starve_cnt_q), 0);
        chk("ct_d_data", a_d_data, 32'hA000_0008);
      end
    end
    chk("ct_f_data", a_f_data, 32'hA000_0004);

    // fetch backpressure: fetch slot held, debug granted each cycle
    a_f_rr = 0; a_f_addr = AW'('h30);
    for (int c = 0; c < 3; c++) begin
      a_d_addr = AW'('h40 + 4 * c);
      #1;
      chk("bp_f_ready", 32'(a_f_rdy), 0);
      chk("bp_d_ready", 32'(a_d_rdy), 1);
      tick;
      chk("bp_f_valid", 32'(a_f_rv), 1);
      chk("bp_f_data", a_f_data, 32'hA000_0004);
      chk("bp_d_data", a_d_data, 32'hA000_0010 + 32'(c));
    end
    a_f_rr = 1;
    #1;
    chk("bp_refill_ready", 32'(a_f_rdy), 1);
    tick;
    chk("bp_refill_valid", 32'(a_f_rv), 1);
    chk("bp_refill_data", a_f_data, 32'hA000_000C);

    // misaligned debug read
    a_f_vld = 0;
    a_d_addr = AW'('h6);
    #1;
    chk("mis_d_ready", 32'(a_d_rdy), 1);
    tick;
    chk("mis_d_data", a_d_data, 32'hA000_0001);
    chk("mis_d_err", 32'(a_d_err), 1);
    chk("mis_f_valid", 32'(a_f_rv), 0);
    a_d_vld = 0;

    // reset mid-operation with both slots full
    a_f_rr = 0; a_d_rr = 0;
    a_f_vld = 1; a_f_addr = AW'('h8);
    a_d_vld = 1; a_d_addr = AW'('hC);
    #1;
    tick;
    chk("rm_f_full", 32'(a_f_rv), 1);
    chk("rm_d_full", 32'(a_d_rv), 1);
    rst = 1'b1; a_f_rr = 1; a_d_rr = 1;
    #1;
    chk("rm_f_ready", 32'(a_f_rdy), 0);
    chk("rm_d_ready", 32'(a_d_rdy), 0);
    tick;
    chk("rm_f_valid", 32'(a_f_rv), 0);
    chk("rm_d_valid", 32'(a_d_rv), 0);
    chk("rm_f_data", a_f_data, 0);
    chk("rm_d_data", a_d_data, 0);
    chk("rm_d_err", 32'(a_d_err), 0);
    chk("rm_starve", 32'(u_a.starve_cnt_q), 0);
    rst = 1'b0;
    #1;
    chk("rm_resume_f", 32'(a_f_rdy), 1);
    chk("rm_resume_d", 32'(a_d_rdy), 0);
    tick;
    chk("rm_resume_data", a_f_data, 32'hA000_0002);
    a_f_vld = 0; a_d_vld = 0;

    // starvation saturation on the STARVE_MAX = 15 instance
    b_d_vld = 1; b_d_addr = AW'('h14);
    #1;
    chk("sat_first_d", 32'(b_d_rdy), 1);
    tick;
    chk("sat_first_data", b_d_data, 32'hA000_0005);
    b_d_rr = 0;
    b_f_vld = 1; b_f_addr = AW'('h0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_d_ready", 32'(b_d_rdy), 0);
      chk("sat_f_ready", 32'(b_f_rdy), 1);
      tick;
      chk("sat_cnt", 32'(u_b.starve_cnt_q), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
      chk("sat_d_data", b_d_data, 32'hA000_0005);
    end
    b_d_rr = 1; b_d_addr = AW'('h18);
    #1;
    chk("sat_free_d", 32'(b_d_rdy), 1);
    chk("sat_free_f", 32'(b_f_rdy), 0);
    tick;
    chk("sat_free_data", b_d_data, 32'hA000_0006);
    chk("sat_free_cnt", 32'(u_b.starve_cnt_q), 0);
    b_f_vld = 0; b_d_vld = 0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for the single-read-port instruction memory. It shares the memory's combinational read port between the instruction-fetch stage and the debug/loader read port. Each requester gets a valid/ready request channel and a registered, back-pressurable response channel. The arbiter sits directly in front of `inst_memory`: it drives `paddr_i` and samples `prdata_o`.

## Interface
Parameters:
- `IMEM_W`, default 14: byte-address width; must match the memory's `IMEM_W`.
- `STARVE_MAX`, default 4: consecutive denied debug cycles after which debug gets priority; legal range 1..15.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `f_req_valid_i` in 1: fetch request valid.
- `f_req_addr_i` in IMEM_W: fetch byte address.
- `f_req_ready_o` out 1: fetch request accepted this cycle.
- `f_rsp_valid_o` out 1: fetch response valid.
- `f_rsp_data_o` out 32: fetch instruction word.
- `f_rsp_err_o` out 1: fetch address misaligned (`addr[1:0]!=0`).
- `f_rsp_ready_i` in 1: fetch consumer ready.
- `d_req_valid_i`, `d_req_addr_i`, `d_req_ready_o`, `d_rsp_valid_o`, `d_rsp_data_o`, `d_rsp_err_o`, `d_rsp_ready_i`: the same signals and widths for the debug port.
- `paddr_o` out IMEM_W: address to the memory's `paddr_i`.
- `prdata_i` in 32: read data from the memory's `prdata_o`; combinational in `paddr_o`.

## Operation
- Slot free: `X_free = !X_rsp_valid_o || X_rsp_ready_i`, for X in {f, d}.
- Eligible: `X_elig = X_req_valid_i && X_free`.
- Priority: fetch wins by default. Debug wins when `starve_cnt >= STARVE_MAX`.
- Grant: at most one grant per cycle.
  - `grant_f = f_elig && !(d_elig && d_prio)`.
  - `grant_d = d_elig && !grant_f`.
- Ready outputs: `X_req_ready_o = grant_X`. These are combinational from the valid inputs, so requesters must not derive valid from ready.
- Memory address: `paddr_o` = address of the granted port. With no grant it is `f_req_addr_i`.
- Response capture on grant: `X_rsp_data_o <= prdata_i`, `X_rsp_err_o <= |addr[1:0]`, `X_rsp_valid_o <= 1`.
- Response hold: without a grant, if `X_rsp_ready_i` then `X_rsp_valid_o <= 0`. Data and err hold their values.
- Data stability: while valid is high and ready is low, data and err stay stable.
- Starvation counter (4 bits):
  - Increments, saturating at 15, when `d_req_valid_i && !grant_d`.
  - Clears when `grant_d` is high or `d_req_valid_i` is low.
- Misaligned addresses are not blocked. The memory ignores `addr[1:0]`, so the aligned word is returned with the err bit set.
- Debug traffic never alters the fetch response register, and fetch traffic never alters the debug response register.

## Timing
- Reset values (next edge after `rst_i` high):
  - `f_rsp_valid_o = d_rsp_valid_o = 0`.
  - `f/d_rsp_data_o = 0`.
  - `f/d_rsp_err_o = 0`.
  - `starve_cnt = 0`.
  - `req_ready_o` is 0 during any cycle in which `rst_i` is high.
- Reset mid-operation: pending responses are discarded, not replayed. Requests granted in the reset cycle are dropped.
- Latency: a request accepted in cycle N has its response valid in cycle N+1.
- Throughput: one response per cycle per port when the consumer holds ready high.
- Drain and refill in the same cycle: if `rsp_valid && rsp_ready` coincides with a new grant, valid stays high with the new data, with no bubble.
- Backpressure: a full slot with ready low gives `req_ready_o = 0` for that port. The other port may still be granted.
- Starvation bound: with both requesting continuously, debug is granted within STARVE_MAX+1 cycles of first asserting valid.

## Test plan
- **Fetch alone.** Memory preloaded with word[k]=0xA000_0000+k. Fetch requests 0x0, 0x4, 0x8 on three consecutive cycles, `f_rsp_ready_i=1`.
  - Required: ready high each cycle; responses 0xA000_0000, 0xA000_0001, 0xA000_0002 on the following three cycles; err 0.
- **Contention.** `STARVE_MAX=4`; both ports request continuously, both response readys high.
  - Required: fetch granted in cycles 0-3; debug granted in cycle 4; counter back to 0; fetch granted in cycle 5.
- **Fetch backpressure.** Fetch response valid with `f_rsp_ready_i=0` for 3 cycles while both ports request.
  - Required: `f_req_ready_o=0` and `f_rsp_data_o` stable for those cycles; debug granted each cycle.
  - Then `f_rsp_ready_i=1` with a new fetch request: new data next cycle, no bubble.
- **Misaligned debug.** Debug request to 0x6.
  - Required: `d_rsp_data_o=0xA000_0001`, `d_rsp_err_o=1`.
- **Reset mid-operation.** Both response slots full, `rst_i` pulsed for 1 cycle with requests pending.
  - Required: both valids 0, data 0, `starve_cnt=0` after the edge; no ready during reset; normal grants resume the cycle after `rst_i` falls.
- **Starvation saturation.** `STARVE_MAX=15`; debug requests while its response slot stays full for 20 cycles.
  - Required: counter saturates at 15 without wrapping; debug granted first cycle its slot frees.
